cva6_lsu_model: RTL and testbench

CVA6_LSU_MODEL -- requirements
Module: cva6_lsu_model

---
 rtl/cva6_lsu_pkg.sv | 12 +
 rtl/cva6_lsu_shim.sv | 30 +++
 rtl/cva6_lsu_store_buffer.sv | 60 ++++++
 rtl/cva6_lsu_model.sv | 79 +++++++
 tb/tb_cva6_lsu_model.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cva6_lsu_pkg.sv
// Shared definitions for the CVA6 load/store unit model.
package cva6_lsu_pkg;

  localparam int unsigned STORE_BUF_DEPTH_DEFAULT = 2;
  localparam int unsigned ADDR_W                  = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } lsu_load_state_t;

endpackage

// File: rtl/cva6_lsu_shim.sv
// Port-identical wrapper around cva6_lsu_model for drop-in integration.
module cva6_lsu_shim
  import cva6_lsu_pkg::*;
#(
  parameter int unsigned STORE_BUF_DEPTH = STORE_BUF_DEPTH_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] instr_i,
  input  logic              is_load_i,
  input  logic              instr_valid_i,
  input  logic              store_mem_resp_i,
  input  logic              load_mem_resp_i,
  output logic              ready_o
);

  cva6_lsu_model #(
    .STORE_BUF_DEPTH (STORE_BUF_DEPTH)
  ) u_model (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .instr_i          (instr_i),
    .is_load_i        (is_load_i),
    .instr_valid_i    (instr_valid_i),
    .store_mem_resp_i (store_mem_resp_i),
    .load_mem_resp_i  (load_mem_resp_i),
    .ready_o          (ready_o)
  );

endmodule

// File: rtl/cva6_lsu_store_buffer.sv
// Store-address FIFO: wrapping read/write pointers plus an occupancy count.
module cva6_lsu_store_buffer
  import cva6_lsu_pkg::*;
#(
  parameter  int unsigned DEPTH = STORE_BUF_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_addr
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_addr = mem_q[rd_ptr_q];

  // A pop on an empty buffer, or a push into a full one, is a no-op.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= addr_in;
        wr_ptr_q        <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cva6_lsu_model.sv
// Cycle model of the CVA6 LSU issue path: one outstanding load, buffered stores.
//
//   state     | meaning
//   IDLE      | no load outstanding; may accept a load
//   WAIT_RESP | load issued, waiting for load_mem_resp_i
module cva6_lsu_model
  import cva6_lsu_pkg::*;
#(
  parameter int unsigned STORE_BUF_DEPTH = STORE_BUF_DEPTH_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] instr_i,
  input  logic              is_load_i,
  input  logic              instr_valid_i,
  input  logic              store_mem_resp_i,
  input  logic              load_mem_resp_i,
  output logic              ready_o
);

  localparam int unsigned CNT_W = $clog2(STORE_BUF_DEPTH + 1);

  lsu_load_state_t   state_q;
  lsu_load_state_t   state_d;
  logic [ADDR_W-1:0] load_addr_q;
  logic              accept;
  logic              load_accept;
  logic              store_accept;
  logic              sb_full;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;
  logic [ADDR_W-1:0] sb_head_addr;
  logic              unused_state_bits;

  // ready_o depends only on flops, so acceptance never loops back through it.
  assign ready_o      = (state_q == IDLE) && !sb_full;
  assign accept       = instr_valid_i && ready_o;
  assign load_accept  = accept && is_load_i;
  assign store_accept = accept && !is_load_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (load_accept) state_d = WAIT_RESP;
      WAIT_RESP: if (load_mem_resp_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_accept) begin
        load_addr_q <= instr_i;
      end
    end
  end

  cva6_lsu_store_buffer #(
    .DEPTH (STORE_BUF_DEPTH)
  ) u_store_buffer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (store_accept),
    .pop       (store_mem_resp_i),
    .addr_in   (instr_i),
    .full      (sb_full),
    .empty     (sb_empty),
    .count     (sb_count),
    .head_addr (sb_head_addr)
  );

  // Address state is held for observability; no forwarding consumes it.
  assign unused_state_bits = ^{load_addr_q, sb_head_addr, sb_count, sb_empty};

endmodule

// File: tb/tb_cva6_lsu_model.sv
// Directed-vector bench for cva6_lsu_model, with a shim equivalence run.
module tb_cva6_lsu_model;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic        is_load_i;
  logic        instr_valid_i;
  logic        store_mem_resp_i;
  logic        load_mem_resp_i;
  logic        ready_o;
  logic        ready_shim;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cva6_lsu_model #(.STORE_BUF_DEPTH(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .instr_i          (instr_i),
    .is_load_i        (is_load_i),
    .instr_valid_i    (instr_valid_i),
    .store_mem_resp_i (store_mem_resp_i),
    .load_mem_resp_i  (load_mem_resp_i),
    .ready_o          (ready_o)
  );

  cva6_lsu_shim #(.STORE_BUF_DEPTH(2)) shim (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .instr_i          (instr_i),
    .is_load_i        (is_load_i),
    .instr_valid_i    (instr_valid_i),
    .store_mem_resp_i (store_mem_resp_i),
    .load_mem_resp_i  (load_mem_resp_i),
    .ready_o          (ready_shim)
  );

  typedef struct {
    logic        vld;
    logic        ld;
    logic [31:0] addr;
    logic        sr;
    logic        lr;
    logic        exp_ready;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: ready got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge and cleared after the next one.
  task automatic step(input logic vld, input logic ld, input logic [31:0] addr,
                      input logic sr, input logic lr, input logic exp, input string name);
    instr_valid_i    = vld;
    is_load_i        = ld;
    instr_i          = addr;
    store_mem_resp_i = sr;
    load_mem_resp_i  = lr;
    @(posedge clk_i);
    #1;
    instr_valid_i    = 1'b0;
    store_mem_resp_i = 1'b0;
    load_mem_resp_i  = 1'b0;
    check(name, ready_o, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ld_pipe;
    logic [2:0]  st_pipe;
    logic        acc;
    logic [31:0] seed_val;

    //           vld   ld    addr          sr    lr    ready after edge
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 32'h00000cad, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h00000cad, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h00000cad, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h00002000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 32'h00002000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h00003000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 32'h00004000, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 32'h00005000, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 32'h00006000, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 1'b1, 32'h00005000, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1};

    rst_ni           = 1'b0;
    instr_i          = '0;
    is_load_i        = 1'b0;
    instr_valid_i    = 1'b0;
    store_mem_resp_i = 1'b0;
    load_mem_resp_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ready", ready_o, 1'b1);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].vld, vecs[i].ld, vecs[i].addr, vecs[i].sr, vecs[i].lr,
           vecs[i].exp_ready, $sformatf("vec%0d", i));
    end

    // Mid-operation reset with a store buffered and a load outstanding.
    step(1'b1, 1'b0, 32'h00000cad, 1'b0, 1'b0, 1'b1, "pre_rst_store");
    step(1'b1, 1'b1, 32'h00000cad, 1'b0, 1'b0, 1'b0, "pre_rst_load");
    rst_ni = 1'b0;
    #1;
    check("rst_async_ready", ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    check("rst_hold1_ready", ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    check("rst_hold2_ready", ready_o, 1'b1);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "post_rst_stale_resp");
    step(1'b1, 1'b0, 32'h00000111, 1'b0, 1'b0, 1'b1, "post_rst_store1");
    step(1'b1, 1'b0, 32'h00000222, 1'b0, 1'b0, 1'b0, "post_rst_store2_full");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "post_rst_pop");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "post_rst_drain");

    // Seeded random mix; responses return three cycles after each accept.
    seed_val = $urandom(32'd2024);
    ld_pipe  = '0;
    st_pipe  = '0;
    for (int c = 0; c < 30; c++) begin
      instr_valid_i    = 1'($urandom_range(0, 1));
      is_load_i        = 1'($urandom_range(0, 1));
      instr_i          = $urandom;
      load_mem_resp_i  = ld_pipe[2];
      store_mem_resp_i = st_pipe[2];
      acc = instr_valid_i && ready_o;
      @(posedge clk_i);
      #1;
      ld_pipe = {ld_pipe[1:0], acc && is_load_i};
      st_pipe = {st_pipe[1:0], acc && !is_load_i};
      instr_valid_i    = 1'b0;
      load_mem_resp_i  = 1'b0;
      store_mem_resp_i = 1'b0;
      check($sformatf("shim_eq_c%0d", c), ready_shim, ready_o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
